// File: rtl/uart_result_sequencer_pkg.sv
// Shared types and constants for the UART result sequencer.
// Frame layout: header, length, payload, XOR checksum.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LEN,
        PAY,
        CSUM
    } seq_state_t;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_result_sequencer_fifo.sv
// Synchronous result FIFO.
// The head entry and the entry behind it are both readable combinationally.
module result_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [WIDTH-1:0]           dout_next_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign dout_o      = mem_q[rd_ptr_q];
    assign dout_next_o = mem_q[rd_ptr_q + AW'(1)];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_result_sequencer.sv
// Buffers array result bytes and emits framed packets (A5, LEN, payload, XOR)
// to the UART byte interface over a valid/ready handshake.
module uart_result_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = 9,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  HDR_BYTE   = HDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    input  logic [7:0]  res_data,
    output logic        res_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_ready,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FRAME_CW = CW'(FRAME_LEN);
    localparam logic [7:0]  LEN_BYTE = 8'(FRAME_LEN);
    localparam logic [7:0]  LAST_IDX = 8'(FRAME_LEN - 1);

    seq_state_t    state_q;
    logic [7:0]    idx_q;
    logic [7:0]    csum_q;
    logic [7:0]    tx_byte_q;
    logic          tx_valid_q;
    logic [15:0]   frame_cnt_q;

    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head, fifo_head_next;
    logic          push, pop, xfer;

    assign xfer = tx_valid_q && tx_ready;
    assign push = res_valid && !fifo_full;
    assign pop  = xfer && (state_q == PAY);

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .din_i       (res_data),
        .dout_o      (fifo_head),
        .dout_next_o (fifo_head_next),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Payload bytes stay in the FIFO until transferred; on each PAY transfer the
    // register reloads from the entry behind the head, which is the new head after the pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            csum_q      <= '0;
            tx_byte_q   <= '0;
            tx_valid_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_count >= FRAME_CW) begin
                        state_q    <= HDR;
                        csum_q     <= '0;
                        tx_byte_q  <= HDR_BYTE;
                        tx_valid_q <= 1'b1;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        csum_q    <= csum_step(csum_q, tx_byte_q);
                        tx_byte_q <= LEN_BYTE;
                        state_q   <= LEN;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        csum_q    <= csum_step(csum_q, tx_byte_q);
                        idx_q     <= '0;
                        tx_byte_q <= fifo_head;
                        state_q   <= PAY;
                    end
                end
                PAY: begin
                    if (xfer) begin
                        csum_q <= csum_step(csum_q, tx_byte_q);
                        idx_q  <= idx_q + 8'd1;
                        if (idx_q == LAST_IDX) begin
                            tx_byte_q <= csum_step(csum_q, tx_byte_q);
                            state_q   <= CSUM;
                        end else begin
                            tx_byte_q <= fifo_head_next;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        tx_valid_q  <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign res_ready = !fifo_full;
    assign tx_valid  = tx_valid_q;
    assign tx_byte   = tx_byte_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != IDLE);

endmodule
